summation_mod_nch: RTL and testbench
====================================

# summation_mod_nch

Multi-channel modulo-M accumulator. It holds N independent counters in the range 0..M-1 and applies one signed add, load or clear per cycle to a selected channel. Each add either wraps modulo M or saturates at the range limits, and every operation returns a registered result with wrap/saturation flags. It generalises the single-channel modulo summation counter for phase/index tracking across several streams, adding saturation mode, per-channel load/clear, input range checking and a valid/channel-tagged result.

## Interface
- M, default 1000: modulus, M ≥ 2; channel values are 0..M-1.
- AW, default 11: addend width, two's complement.
- N, default 4: channel count, N ≥ 1.
- Derived: CW = clog2(M) count width; CHW = max(1, clog2(N)) channel index width.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  reset, asynchronous, active-low; clears all state.
- in_valid  in  1  operation request, one per cycle, always accepted.
- in_ch  in  CHW  target channel; values ≥ N are an error.
- in_op  in  2  00 add, 01 load, 10 clear, 11 reserved.
- addend  in  AW  signed operand for add; unsigned value for load.
- mode  in  1  0 wrap, 1 saturate; sampled with the request.
- out_valid  out  1  result strobe.
- out_ch  out  CHW  channel of the result.
- out_cnt  out  CW  channel value after the operation.
- cop  out  1  add overflowed the upper bound (wrapped or clamped).
- con  out  1  add underflowed below 0 (wrapped or clamped).
- err  out  1  request rejected; channel unchanged.
- cnt_all  out  N*CW  all channel values; channel i occupies bits [i*CW +: CW].

## Operation
- State: N registers cnt[i] of CW bits. Reset value is 0 for every cnt[i]; out_valid, out_ch, out_cnt, cop, con and err also reset to 0.
- Arithmetic: sign-extend addend and zero-extend cnt to max(CW, AW)+2 bits. Then sum = cnt[ch] + addend.
- add, mode 0 (wrap):
  - sum ≥ M: new value = sum − M, cop = 1.
  - sum < 0: new value = sum + M, con = 1.
  - Otherwise new value = sum, both flags 0.
- add, mode 1 (saturate):
  - sum > M−1: new value = M−1, cop = 1.
  - sum < 0: new value = 0, con = 1.
  - Otherwise new value = sum.
- load: new value = addend, read as unsigned. cop = con = 0.
- clear: new value = 0. cop = con = 0.
- Error conditions set err = 1 and leave the channel unchanged:
  - in_ch ≥ N.
  - in_op = 11.
  - add with addend outside −(M−1)..M−1, so a single wrap always suffices.
  - load with addend outside 0..M−1.
- Error response: out_valid still asserts. out_cnt shows the unchanged channel value, or 0 if in_ch ≥ N. cop = con = 0.
- Exactly one of cop/con can be set per result. Flags are meaningful only while out_valid = 1.
- The mode input affects add only.

## Timing
- Single-stage read-modify-write. A request sampled at edge k updates cnt[in_ch] at edge k.
- At edge k, out_valid, out_ch, out_cnt, cop, con and err register the result. They are visible in cycle k+1, so latency is 1 cycle.
- out_valid is high for exactly one cycle per request and low in any cycle following in_valid = 0. The other outputs hold their last values while out_valid = 0.
- Back-to-back requests to the same channel have no hazard: each sees the value written by the previous edge.
- cnt_all reflects register state directly and updates on the same edge as out_cnt.
- Reset asserted mid-operation clears all state immediately and asynchronously, and out_valid drops. A request sampled on the edge where arst deasserts is ignored. The first accepted request is on the following edge.

## Test plan
Parameters M=1000, AW=11, N=4 unless stated.
- Reset, then ch0 add 994 (mode 0) → out_cnt 994, cop 0. Then add 10 → out_cnt 4, cop 1. Then add −5 → out_cnt 999, con 1.
- ch1 mode 1: load 990, add 20 → out_cnt 999, cop 1. Load 5, add −9 → out_cnt 0, con 1. ch0 in cnt_all is unchanged.
- Errors, all with err 1 and channel values unchanged:
  - ch2 add 1000.
  - ch2 add −1000.
  - load 1000.
  - in_op 11.
  - Repeat with N=3 and in_ch 3 → err 1, out_cnt 0.
- Back-to-back adds of 999 on ch3 for 5 cycles from 0 → out_cnt 999, 998, 997, 996, 995, with cop 1 from the second result on. Interleave ch0 clear → ch0 reads 0 and ch3 is unaffected.
- Assert arst low mid-burst → cnt_all 0 and out_valid 0 immediately. Release → first result appears 2 edges after the first post-release request.
- Randomised sweep against a reference model with M=7, AW=4, N=2: every legal add/load/clear in both modes matches out_cnt, cop, con and err.

Source files
------------

// File: rtl/summation_mod_nch.sv
// Multi-channel modulo-M accumulator.
// One add/load/clear per cycle to a selected channel, registered result.
module summation_mod_nch #(
    parameter int M = 1000,
    parameter int AW = 11,
    parameter int N = 4,
    localparam int CW = $clog2(M),
    localparam int CHW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            in_valid,
    input  logic [CHW-1:0]  in_ch,
    input  logic [1:0]      in_op,
    input  logic [AW-1:0]   addend,
    input  logic            mode,
    output logic            out_valid,
    output logic [CHW-1:0]  out_ch,
    output logic [CW-1:0]   out_cnt,
    output logic            cop,
    output logic            con,
    output logic            err,
    output logic [N*CW-1:0] cnt_all
);

    localparam int EW = ((CW > AW) ? CW : AW) + 2;
    localparam logic signed [EW-1:0] MS = EW'(M);
    localparam logic signed [EW-1:0] MAX = EW'(M - 1);
    localparam logic signed [EW-1:0] NMAX = -MAX;

    logic [CW-1:0] cnt [N];
    logic          run;
    logic          ch_ok;
    logic          bad;
    logic          cp;
    logic          cn;
    logic          accept;
    logic [CW-1:0] cur;
    logic [CW-1:0] nxt;
    logic [CW-1:0] res;

    logic signed [EW-1:0] add_s;
    logic signed [EW-1:0] ld_s;
    logic signed [EW-1:0] cnt_s;
    logic signed [EW-1:0] sum;

    for (genvar g = 0; g < N; g++) begin : g_all
        assign cnt_all[g*CW +: CW] = cnt[g];
    end

    assign ch_ok = {{(32-CHW){1'b0}}, in_ch} < 32'(N);
    assign add_s = {{(EW-AW){addend[AW-1]}}, addend};
    assign ld_s = {{(EW-AW){1'b0}}, addend};
    assign cnt_s = {{(EW-CW){1'b0}}, cur};
    assign sum = cnt_s + add_s;
    assign accept = in_valid & run;

    // select the addressed channel; out-of-range channels read as 0
    always_comb begin
        cur = '0;
        for (int i = 0; i < N; i++) begin
            if (in_ch == CHW'(i)) cur = cnt[i];
        end
    end

    // compute the new value, flags and rejection for the request
    always_comb begin
        nxt = cur;
        cp = 1'b0;
        cn = 1'b0;
        bad = !ch_ok;
        case (in_op)
            2'b00: begin
                if (add_s > MAX || add_s < NMAX) begin
                    bad = 1'b1;
                end else if (!mode) begin
                    if (sum >= MS) begin
                        nxt = CW'(sum - MS);
                        cp = 1'b1;
                    end else if (sum < 0) begin
                        nxt = CW'(sum + MS);
                        cn = 1'b1;
                    end else begin
                        nxt = CW'(sum);
                    end
                end else begin
                    if (sum > MAX) begin
                        nxt = CW'(MAX);
                        cp = 1'b1;
                    end else if (sum < 0) begin
                        nxt = '0;
                        cn = 1'b1;
                    end else begin
                        nxt = CW'(sum);
                    end
                end
            end
            2'b01: begin
                if (ld_s > MAX) bad = 1'b1;
                else nxt = CW'(ld_s);
            end
            2'b10: nxt = '0;
            default: bad = 1'b1;
        endcase
        res = bad ? cur : nxt;
    end

    // requests are ignored on the first edge after reset release
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) run <= 1'b0;
        else run <= 1'b1;
    end

    // channel register file update
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else if (accept && !bad) begin
            for (int i = 0; i < N; i++) begin
                if (in_ch == CHW'(i)) cnt[i] <= nxt;
            end
        end
    end

    // registered result; fields hold while no request arrives
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            out_valid <= 1'b0;
            out_ch <= '0;
            out_cnt <= '0;
            cop <= 1'b0;
            con <= 1'b0;
            err <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_ch <= in_ch;
                out_cnt <= res;
                cop <= cp & !bad;
                con <= cn & !bad;
                err <= bad;
            end
        end
    end

endmodule

// File: tb/tb_summation_mod_nch.sv
// Bench for summation_mod_nch: vector table, corner sequences,
// and a randomised model sweep on a small configuration.
module tb_summation_mod_nch;

    typedef struct {
        int ch;
        int cnt;
        int cop;
        int con;
        int err;
    } exp_t;

    typedef struct {
        int ch;
        int op;
        int ad;
        int md;
        int cnt;
        int cop;
        int con;
        int err;
    } vec_t;

    logic clk = 1'b0;
    logic arst;
    int nchk = 0;
    int nerr = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    // instance a: M=1000 AW=11 N=4
    logic        a_valid;
    logic [1:0]  a_ch;
    logic [1:0]  a_op;
    logic [10:0] a_add;
    logic        a_mode;
    logic        a_ovalid;
    logic [1:0]  a_och;
    logic [9:0]  a_cnt;
    logic        a_cop;
    logic        a_con;
    logic        a_err;
    logic [39:0] a_all;

    // instance b: M=1000 AW=11 N=3
    logic        b_valid;
    logic [1:0]  b_ch;
    logic [1:0]  b_op;
    logic [10:0] b_add;
    logic        b_mode;
    logic        b_ovalid;
    logic [1:0]  b_och;
    logic [9:0]  b_cnt;
    logic        b_cop;
    logic        b_con;
    logic        b_err;
    logic [29:0] b_all;

    // instance c: M=7 AW=4 N=2
    logic        c_valid;
    logic [0:0]  c_ch;
    logic [1:0]  c_op;
    logic [3:0]  c_add;
    logic        c_mode;
    logic        c_ovalid;
    logic [0:0]  c_och;
    logic [2:0]  c_cnt;
    logic        c_cop;
    logic        c_con;
    logic        c_err;
    logic [5:0]  c_all;

    summation_mod_nch u_a (
        .clk(clk), .arst(arst), .in_valid(a_valid), .in_ch(a_ch),
        .in_op(a_op), .addend(a_add), .mode(a_mode),
        .out_valid(a_ovalid), .out_ch(a_och), .out_cnt(a_cnt),
        .cop(a_cop), .con(a_con), .err(a_err), .cnt_all(a_all)
    );

    summation_mod_nch #(.M(1000), .AW(11), .N(3)) u_b (
        .clk(clk), .arst(arst), .in_valid(b_valid), .in_ch(b_ch),
        .in_op(b_op), .addend(b_add), .mode(b_mode),
        .out_valid(b_ovalid), .out_ch(b_och), .out_cnt(b_cnt),
        .cop(b_cop), .con(b_con), .err(b_err), .cnt_all(b_all)
    );

    summation_mod_nch #(.M(7), .AW(4), .N(2)) u_c (
        .clk(clk), .arst(arst), .in_valid(c_valid), .in_ch(c_ch),
        .in_op(c_op), .addend(c_add), .mode(c_mode),
        .out_valid(c_ovalid), .out_ch(c_och), .out_cnt(c_cnt),
        .cop(c_cop), .con(c_con), .err(c_err), .cnt_all(c_all)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // scoreboard monitors: pop the oldest expectation per result
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_ovalid) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_valid", 1, 0);
            end else begin
                e = qa.pop_front();
                chk("a_out_ch", int'(a_och), e.ch);
                chk("a_out_cnt", int'(a_cnt), e.cnt);
                chk("a_cop", int'(a_cop), e.cop);
                chk("a_con", int'(a_con), e.con);
                chk("a_err", int'(a_err), e.err);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_ovalid) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_valid", 1, 0);
            end else begin
                e = qb.pop_front();
                chk("b_out_ch", int'(b_och), e.ch);
                chk("b_out_cnt", int'(b_cnt), e.cnt);
                chk("b_cop", int'(b_cop), e.cop);
                chk("b_con", int'(b_con), e.con);
                chk("b_err", int'(b_err), e.err);
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (c_ovalid) begin
            if (qc.size() == 0) begin
                chk("c_unexpected_valid", 1, 0);
            end else begin
                e = qc.pop_front();
                chk("c_out_ch", int'(c_och), e.ch);
                chk("c_out_cnt", int'(c_cnt), e.cnt);
                chk("c_cop", int'(c_cop), e.cop);
                chk("c_con", int'(c_con), e.con);
                chk("c_err", int'(c_err), e.err);
            end
        end
    end

    task automatic op_a(input int ch, input int op, input int ad,
                        input int md, input int cnt, input int cp,
                        input int cn, input int er);
        @(negedge clk);
        a_valid = 1'b1;
        a_ch = 2'(ch);
        a_op = 2'(op);
        a_add = 11'(ad);
        a_mode = 1'(md);
        qa.push_back('{ch, cnt, cp, cn, er});
    endtask

    task automatic op_b(input int ch, input int op, input int ad,
                        input int cnt, input int er);
        @(negedge clk);
        b_valid = 1'b1;
        b_ch = 2'(ch);
        b_op = 2'(op);
        b_add = 11'(ad);
        b_mode = 1'b0;
        qb.push_back('{ch, cnt, 0, 0, er});
    endtask

    task automatic idle_all();
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        c_valid = 1'b0;
    endtask

    vec_t tbl[13];
    int mc[2];
    int ch, op, u, sa, s, md, cur, nv, cp, cn, er;

    initial begin
        tbl[0]  = '{0, 0, 994, 0, 994, 0, 0, 0};
        tbl[1]  = '{0, 0, 10, 0, 4, 1, 0, 0};
        tbl[2]  = '{0, 0, -5, 0, 999, 0, 1, 0};
        tbl[3]  = '{1, 1, 990, 1, 990, 0, 0, 0};
        tbl[4]  = '{1, 0, 20, 1, 999, 1, 0, 0};
        tbl[5]  = '{1, 1, 5, 1, 5, 0, 0, 0};
        tbl[6]  = '{1, 0, -9, 1, 0, 0, 1, 0};
        tbl[7]  = '{2, 0, 1000, 0, 0, 0, 0, 1};
        tbl[8]  = '{2, 0, -1000, 0, 0, 0, 0, 1};
        tbl[9]  = '{2, 1, 1000, 0, 0, 0, 0, 1};
        tbl[10] = '{0, 3, 1, 0, 999, 0, 0, 1};
        tbl[11] = '{2, 0, 999, 0, 999, 0, 0, 0};
        tbl[12] = '{2, 0, -999, 1, 0, 0, 0, 0};

        a_valid = 0; a_ch = 0; a_op = 0; a_add = 0; a_mode = 0;
        b_valid = 0; b_ch = 0; b_op = 0; b_add = 0; b_mode = 0;
        c_valid = 0; c_ch = 0; c_op = 0; c_add = 0; c_mode = 0;
        mc[0] = 0;
        mc[1] = 0;
        arst = 1'b1;
        #1 arst = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(a_ovalid), 0);
        chk("rst_out_cnt", int'(a_cnt), 0);
        chk("rst_err", int'(a_err), 0);
        chk("rst_cop_con", int'({a_cop, a_con}), 0);
        chk("rst_cnt_all_lo", int'(a_all[19:0]), 0);
        chk("rst_cnt_all_hi", int'(a_all[39:20]), 0);
        chk("rst_b_valid", int'(b_ovalid), 0);
        chk("rst_c_valid", int'(c_ovalid), 0);
        arst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            op_a(tbl[i].ch, tbl[i].op, tbl[i].ad, tbl[i].md,
                 tbl[i].cnt, tbl[i].cop, tbl[i].con, tbl[i].err);
        end
        idle_all();
        chk("tbl_cnt_all_ch0", int'(a_all[0 +: 10]), 999);
        chk("tbl_cnt_all_ch1", int'(a_all[10 +: 10]), 0);
        chk("tbl_cnt_all_ch2", int'(a_all[20 +: 10]), 0);

        op_b(2, 0, 5, 5, 0);
        op_b(3, 0, 1, 0, 1);
        op_b(3, 1, 2, 0, 1);
        op_b(2, 0, 7, 12, 0);
        idle_all();
        chk("b_cnt_all_ch2", int'(b_all[20 +: 10]), 12);

        op_a(3, 0, 999, 0, 999, 0, 0, 0);
        op_a(3, 0, 999, 0, 998, 1, 0, 0);
        op_a(3, 0, 999, 0, 997, 1, 0, 0);
        op_a(0, 2, 0, 0, 0, 0, 0, 0);
        op_a(3, 0, 999, 0, 996, 1, 0, 0);
        op_a(3, 0, 999, 0, 995, 1, 0, 0);
        idle_all();
        chk("b2b_cnt_all_ch3", int'(a_all[30 +: 10]), 995);
        chk("b2b_cnt_all_ch0", int'(a_all[0 +: 10]), 0);
        chk("b2b_cnt_all_ch1", int'(a_all[10 +: 10]), 0);

        for (int k = 0; k < 300; k++) begin
            ch = $urandom_range(0, 1);
            op = $urandom_range(0, 3);
            u = $urandom_range(0, 15);
            md = $urandom_range(0, 1);
            sa = (u >= 8) ? u - 16 : u;
            cur = mc[ch];
            nv = cur;
            cp = 0;
            cn = 0;
            er = 0;
            case (op)
                0: begin
                    if (sa > 6 || sa < -6) begin
                        er = 1;
                    end else begin
                        s = cur + sa;
                        if (s > 6) begin
                            nv = (md == 0) ? s - 7 : 6;
                            cp = 1;
                        end else if (s < 0) begin
                            nv = (md == 0) ? s + 7 : 0;
                            cn = 1;
                        end else begin
                            nv = s;
                        end
                    end
                end
                1: if (u > 6) er = 1; else nv = u;
                2: nv = 0;
                default: er = 1;
            endcase
            if (er == 0) mc[ch] = nv;
            @(negedge clk);
            c_valid = 1'b1;
            c_ch = 1'(ch);
            c_op = 2'(op);
            c_add = 4'(u);
            c_mode = 1'(md);
            qc.push_back('{ch, nv, cp, cn, er});
        end
        idle_all();
        chk("c_cnt_all_ch0", int'(c_all[2:0]), mc[0]);
        chk("c_cnt_all_ch1", int'(c_all[5:3]), mc[1]);

        op_a(3, 0, 1, 0, 996, 0, 0, 0);
        op_a(3, 0, 1, 0, 997, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("pre_rst_valid", int'(a_ovalid), 1);
        arst = 1'b0;
        a_valid = 1'b0;
        #1;
        qa.delete();
        chk("mid_rst_valid", int'(a_ovalid), 0);
        chk("mid_rst_all_lo", int'(a_all[19:0]), 0);
        chk("mid_rst_all_hi", int'(a_all[39:20]), 0);

        repeat (2) @(negedge clk);
        arst = 1'b1;
        a_valid = 1'b1;
        a_ch = 2'd0;
        a_op = 2'd0;
        a_add = 11'd7;
        a_mode = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_edge_ignored", int'(a_ovalid), 0);
        qa.push_back('{0, 7, 0, 0, 0});
        @(posedge clk);
        #1;
        chk("rel_first_result", int'(a_ovalid), 1);
        a_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        chk("c_queue_drained", qc.size(), 0);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
